uart_apb_master: RTL and testbench

APB initiator that issues single read/write transfers to the UART's APB register port on behalf of a local controller (CPU shim, test sequencer, loopback engine). It accepts one command at a time over a valid/ready interface and runs the APB SETUP/ACCESS sequence. It waits for PREADY, with a bounded timeout, and returns read data and error status over a held response handshake.

---
 rtl/uart_apb_pkg.sv | 22 ++
 rtl/uart_apb_master_if.sv | 56 +++++
 rtl/uart_apb_master.sv | 125 ++++++++++++
 tb/tb_uart_apb_master.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// -----------------------------------------------------------------------------
// uart_apb_pkg
// Definitions shared by the UART APB initiator and anything that talks to the
// UART register port.
//   apb_state_e   : transfer sequencer states (IDLE, SETUP, ACCESS, RESP)
//   ADDR_DIVXR    : baud divisor register (write)
//   ADDR_TXFIFO   : transmit FIFO push (write)
//   Any read returns the RX FIFO head regardless of address.
// -----------------------------------------------------------------------------
package uart_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [7:0] ADDR_DIVXR  = 8'h01;
  localparam logic [7:0] ADDR_TXFIFO = 8'h02;

endpackage

// File: rtl/uart_apb_master_if.sv
// -----------------------------------------------------------------------------
// uart_apb_master_if
// Bundles the command/response handshake and the APB bus of the UART APB
// initiator.
//   master modport : the initiator (drives cmd_ready, rsp_*, PADDR, PWDATA,
//                    PSEL, PENABLE, PWRITE)
//   slave modport  : everything around it (command source, response sink and
//                    APB completer)
// -----------------------------------------------------------------------------
interface uart_apb_master_if #(
  parameter int APB_DW = 8
);

  // Command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [APB_DW-1:0] cmd_addr;
  logic [APB_DW-1:0] cmd_wdata;

  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [APB_DW-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  // APB
  logic [APB_DW-1:0] PADDR;
  logic [APB_DW-1:0] PWDATA;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic              PREADY;
  logic              PSLVERR;
  logic [APB_DW-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PADDR, PWDATA, PSEL, PENABLE, PWRITE,
    output PREADY, PSLVERR, PRDATA
  );

endinterface

// File: rtl/uart_apb_master.sv
// -----------------------------------------------------------------------------
// uart_apb_master
// Single-transfer APB initiator for the UART register port. Takes one command
// at a time, runs SETUP/ACCESS, waits for PREADY with an optional timeout and
// holds the response until the consumer accepts it.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : uart_apb_master_if.master (command, response and APB signals)
// Parameters
//   APB_DW  : address/data width (must match the interface instance)
//   TIMEOUT : ACCESS cycles before abort; 0 waits forever
// Every output is a register; each is loaded with its value for the state
// being entered, so outputs and state change on the same edge.
// -----------------------------------------------------------------------------
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int APB_DW  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_apb_master_if.master     bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETUP  = SETUP;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP   = RESP;

  // A zero-width counter is illegal, so keep one bit when the timeout is off.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;

  logic             timeout_hit;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values; blocking here would create ordering races.
  // NOTE: the reset is synchronous and this block holds only control/data
  // registers (no arrays), so every register is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.PWRITE    <= bus.cmd_write;
            bus.PADDR     <= bus.cmd_addr;
            bus.PWDATA    <= bus.cmd_wdata;
            bus.PSEL      <= 1'b1;
            bus.cmd_ready <= 1'b0;
            wait_cnt      <= '0;
            state         <= S_SETUP;
          end else begin
            // Covers the first cycle after reset, when cmd_ready is still low.
            bus.cmd_ready <= 1'b1;
          end
        end

        S_SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= S_ACCESS;
        end

        S_ACCESS: begin
          // PREADY is checked first so it wins over a coincident timeout.
          if (bus.PREADY) begin
            bus.rsp_rdata   <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.rsp_err     <= bus.PSLVERR;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            state           <= S_RESP;
          end else if (timeout_hit) begin
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            state           <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          // cmd_ready rises only after the handshake edge, so a new command
          // can never be taken in the same cycle as the response.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: begin
          bus.PSEL      <= 1'b0;
          bus.PENABLE   <= 1'b0;
          bus.rsp_valid <= 1'b0;
          bus.cmd_ready <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_master
// Directed bench for uart_apb_master (TIMEOUT=4). A small UART completer model
// answers APB transfers: PREADY after a programmable number of ACCESS cycles
// (1 for the real UART), a divisor and TX register for writes, and a one-entry
// RX holding register for reads (PSLVERR when empty).
// -----------------------------------------------------------------------------
module tb_uart_apb_master;
  import uart_apb_pkg::*;

  localparam int DW  = 8;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_apb_master_if #(.APB_DW(DW)) bus();

  uart_apb_master #(.APB_DW(DW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- completer model ----------------
  logic [7:0] delay   = 8'd1;
  logic [7:0] acc_cnt = 8'd0;
  logic [7:0] divisor = 8'h00;
  logic [7:0] tx_last = 8'h00;
  logic [7:0] rx_head = 8'h00;
  logic       rx_full = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_load;

  assign bus.PREADY  = bus.PSEL && bus.PENABLE && (acc_cnt >= delay);
  assign bus.PSLVERR = bus.PSEL && bus.PENABLE && !bus.PWRITE && !rx_full;
  assign bus.PRDATA  = rx_full ? rx_head : 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      acc_cnt <= 8'd0;
    end else begin
      acc_cnt <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? acc_cnt + 8'd1 : 8'd0;
      if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
        if (bus.PWRITE) begin
          if (bus.PADDR == ADDR_DIVXR)       divisor <= bus.PWDATA;
          else if (bus.PADDR == ADDR_TXFIFO) tx_last <= bus.PWDATA;
        end else begin
          rx_full <= 1'b0;
        end
      end
      if (rx_load) begin
        rx_full <= 1'b1;
        rx_head <= rx_byte;
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] r_rdata;
  logic       r_err;
  logic       r_tmo;
  logic       r_stable;
  int         r_lat;
  int         r_en;

  // Presents one command, then follows it to rsp_valid (bounded). r_lat is the
  // number of cycles from the accept edge until rsp_valid is visible.
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    check("setup_phase", {bus.PSEL, bus.PENABLE}, 2'b10);
    r_lat    = 1;
    r_en     = 0;
    r_stable = 1'b1;
    while (!bus.rsp_valid && r_lat < 40) begin
      if (bus.PENABLE) r_en++;
      if (!bus.PSEL || bus.PADDR !== a || bus.PWRITE !== w || (w && bus.PWDATA !== d))
        r_stable = 1'b0;
      step();
      r_lat++;
    end
    check("rsp_valid_seen", bus.rsp_valid, 1'b1);
    check("bus_idle_in_resp", {bus.PSEL, bus.PENABLE}, 2'b00);
    r_rdata = bus.rsp_rdata;
    r_err   = bus.rsp_err;
    r_tmo   = bus.rsp_timeout;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("rsp_dropped", bus.rsp_valid, 1'b0);
    check("ready_after_hs", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    bus.rsp_ready = 1'b0;
    rx_load       = 1'b0;
    rx_byte       = 8'h00;

    // Reset state
    step();
    step();
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_psel_pen",  {bus.PSEL, bus.PENABLE}, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_flags", {bus.rsp_err, bus.rsp_timeout}, 2'b00);
    check("rst_paddr",     bus.PADDR, 8'h00);
    rst = 1'b0;
    step();
    check("ready_after_rst", bus.cmd_ready, 1'b1);

    // Write divisor: one wait cycle from the UART
    issue(1'b1, ADDR_DIVXR, 8'h1B);
    check("wr_latency",  r_lat, 4);
    check("wr_en_cycles", r_en, 2);
    check("wr_stable",   r_stable, 1'b1);
    check("wr_err",      {r_err, r_tmo}, 2'b00);
    check("wr_rdata",    r_rdata, 8'h00);
    check("wr_divisor",  divisor, 8'h1B);
    finish_rsp();

    // Read with RX empty -> slave error, no timeout
    issue(1'b0, 8'h00, 8'h00);
    check("rd_empty_lat",  r_lat, 4);
    check("rd_empty_err",  {r_err, r_tmo}, 2'b10);
    check("rd_empty_data", r_rdata, 8'h00);
    finish_rsp();

    // Byte 0x55 received, then read
    rx_byte = 8'h55;
    rx_load = 1'b1;
    step();
    rx_load = 1'b0;
    issue(1'b0, 8'h00, 8'h00);
    check("rd_data",  r_rdata, 8'h55);
    check("rd_err",   {r_err, r_tmo}, 2'b00);
    check("rd_popped", rx_full, 1'b0);
    finish_rsp();

    // Timeout: completer never ready, RX holds data that must not leak out
    rx_byte = 8'hAA;
    rx_load = 1'b1;
    step();
    rx_load = 1'b0;
    delay = 8'hFF;
    issue(1'b0, 8'h00, 8'h00);
    check("tmo_en_cycles", r_en, TMO);
    check("tmo_latency",   r_lat, TMO + 2);
    check("tmo_flags",     {r_err, r_tmo}, 2'b11);
    check("tmo_rdata",     r_rdata, 8'h00);
    delay = 8'd1;

    // Response held while rsp_ready stays low
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", bus.rsp_valid, 1'b1);
      check("hold_flags", {bus.rsp_err, bus.rsp_timeout}, 2'b11);
      check("hold_rdata", bus.rsp_rdata, 8'h00);
      check("hold_cmd_ready", bus.cmd_ready, 1'b0);
    end
    finish_rsp();

    // Next command right after the handshake; PREADY coincides with the
    // last timeout cycle and must win.
    delay = 8'd3;
    issue(1'b1, ADDR_TXFIFO, 8'h3C);
    check("tie_latency",   r_lat, 6);
    check("tie_en_cycles", r_en, 4);
    check("tie_flags",     {r_err, r_tmo}, 2'b00);
    check("tie_tx",        tx_last, 8'h3C);
    finish_rsp();
    delay = 8'd1;

    // Reset during ACCESS discards the transfer
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = ADDR_DIVXR;
    bus.cmd_wdata = 8'h77;
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    check("pre_rst_access", {bus.PSEL, bus.PENABLE}, 2'b11);
    rst = 1'b1;
    step();
    check("midrst_psel_pen",  {bus.PSEL, bus.PENABLE}, 2'b00);
    check("midrst_cmd_ready", bus.cmd_ready, 1'b0);
    check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_rsp", bus.rsp_valid, 1'b0);
    end
    check("post_rst_ready",   bus.cmd_ready, 1'b1);
    check("post_rst_divisor", divisor, 8'h1B);

    issue(1'b1, ADDR_TXFIFO, 8'hA5);
    check("fresh_latency", r_lat, 4);
    check("fresh_err",     {r_err, r_tmo}, 2'b00);
    check("fresh_tx",      tx_last, 8'hA5);
    finish_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
